mem_loader: RTL and testbench

- Bulk-write front end that sits directly upstream of the unified memory, on its write/address port.
- In IDLE it passes the CPU's memory signals (addr, data, write enable) straight through to the memory.
- On start it holds the CPU off and accepts a valid/ready word stream, writing each word to consecutive addresses from a base address.
- It keeps a running checksum so the program image can be confirmed after loading.

---
 rtl/mem_loader.sv | 117 +++++++++++
 tb/tb_mem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - bulk stream loader in front of the unified memory write/address port
module mem_loader #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [ADDR_SIZE-1:0] i_base_addr,
    input  logic [ADDR_SIZE:0]   i_length,
    input  logic [WORD_SIZE-1:0] i_in_data,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [ADDR_SIZE-1:0] i_cpu_addr,
    input  logic [WORD_SIZE-1:0] i_cpu_data,
    input  logic                 i_cpu_en_write,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_data_in,
    output logic                 o_mem_en_write,
    output logic                 o_cpu_hold,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [WORD_SIZE-1:0] o_checksum,
    output logic [ADDR_SIZE:0]   o_words_written
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_ptr;
    logic [ADDR_SIZE:0]   r_rem;
    logic [WORD_SIZE-1:0] r_checksum;
    logic [ADDR_SIZE:0]   r_words;
    logic                 r_done;
    logic                 r_aborted;

    logic w_idle;
    logic w_load;
    logic w_accept;

    assign w_idle   = (r_state == S_IDLE);
    assign w_load   = (r_state == S_LOAD);
    // Write strobe and handshake are gated only by the registered state, so
    // a transfer and its memory write always happen on the same edge.
    assign w_accept = w_load & i_in_valid & ~i_abort;

    assign o_in_ready     = w_load & ~i_abort;
    assign o_mem_addr     = w_idle ? i_cpu_addr     : r_ptr;
    assign o_mem_data_in  = w_idle ? i_cpu_data     : i_in_data;
    assign o_mem_en_write = w_idle ? i_cpu_en_write : w_accept;

    assign o_cpu_hold      = ~w_idle;
    assign o_busy          = w_load;
    assign o_done          = r_done;
    assign o_aborted       = r_aborted;
    assign o_checksum      = r_checksum;
    assign o_words_written = r_words;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_checksum <= '0;
            r_words    <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr      <= i_base_addr;
                        r_rem      <= i_length;
                        r_checksum <= '0;
                        r_words    <= '0;
                        if (i_length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                    end else if (i_in_valid) begin
                        r_ptr      <= r_ptr + 1'b1;
                        r_rem      <= r_rem - 1'b1;
                        r_checksum <= r_checksum + i_in_data;
                        r_words    <= r_words + 1'b1;
                        if (r_rem == {{ADDR_SIZE{1'b0}}, 1'b1}) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized and directed bench for mem_loader against a transaction-level model
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] length = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_data = '0;
    logic       cpu_en_write = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_en_write;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] checksum;
    logic [8:0] words_written;

    int total = 0;
    int bad = 0;

    mem_loader #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_base_addr(base_addr), .i_length(length),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data), .i_cpu_en_write(cpu_en_write),
        .o_mem_addr(mem_addr), .o_mem_data_in(mem_data_in), .o_mem_en_write(mem_en_write),
        .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done), .o_aborted(aborted),
        .o_checksum(checksum), .o_words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory as seen through the DUT port, and memory as the model says it must be.
    logic [7:0] dmem [256];
    logic [7:0] emem [256];
    int         done_cnt = 0;

    // Model: a load is "words still owed"; a finished load shows done for one cycle.
    bit         m_loading = 0;
    bit         m_finishing = 0;
    bit         m_abort_flag = 0;
    int         m_next = 0;
    int         m_left = 0;
    int         m_sum = 0;
    int         m_count = 0;
    bit         checking = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
            emem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (mem_en_write) dmem[mem_addr] <= mem_data_in;
    end

    always @(posedge clk) begin
        bit idle;
        idle = !m_loading && !m_finishing;
        if (rst) begin
            m_loading = 0; m_finishing = 0; m_abort_flag = 0;
            m_next = 0; m_left = 0; m_sum = 0; m_count = 0;
        end else begin
            m_abort_flag = 0;
            if (idle) begin
                if (cpu_en_write) emem[cpu_addr] = cpu_data;
                if (start) begin
                    m_next = base_addr; m_left = length; m_sum = 0; m_count = 0;
                    if (length == 0) m_finishing = 1;
                    else m_loading = 1;
                end
            end else if (m_loading) begin
                if (abort) begin
                    m_loading = 0;
                    m_abort_flag = 1;
                end else if (in_valid) begin
                    emem[m_next] = in_data;
                    m_next = (m_next + 1) % 256;
                    m_sum = (m_sum + in_data) % 256;
                    m_count = m_count + 1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_loading = 0;
                        m_finishing = 1;
                    end
                end
            end else begin
                m_finishing = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit idle;
        if (done) done_cnt++;
        if (checking) begin
            idle = !m_loading && !m_finishing;
            chk("in_ready", in_ready, m_loading && !abort);
            chk("mem_en_write", mem_en_write, idle ? cpu_en_write : (m_loading && in_valid && !abort));
            chk("mem_addr", mem_addr, idle ? cpu_addr : m_next[7:0]);
            chk("mem_data_in", mem_data_in, idle ? cpu_data : in_data);
            chk("cpu_hold", cpu_hold, !idle);
            chk("busy", busy, m_loading);
            chk("done", done, m_finishing);
            chk("aborted", aborted, m_abort_flag);
            chk("checksum", checksum, m_sum[7:0]);
            chk("words_written", words_written, m_count[8:0]);
        end
    end

    task automatic begin_load(input logic [7:0] b, input logic [8:0] n);
        base_addr = b; length = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] w);
        in_valid = 1'b1; in_data = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int mism;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checking = 1;
        chk("reset_checksum", checksum, 8'h00);
        chk("reset_words", words_written, 9'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // Basic load with a two-cycle gap after the second word.
        d0 = done_cnt;
        begin_load(8'h10, 9'd4);
        chk("t1_hold_after_start", cpu_hold, 1'b1);
        send(8'h11); send(8'h22);
        step(); step();
        send(8'h33); send(8'h44);
        chk("t1_done", done, 1'b1);
        chk("t1_hold_in_done", cpu_hold, 1'b1);
        chk("t1_checksum", checksum, 8'hAA);
        chk("t1_words", words_written, 9'd4);
        step();
        chk("t1_hold_released", cpu_hold, 1'b0);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_mem10", dmem[8'h10], 8'h11);
        chk("t1_mem13", dmem[8'h13], 8'h44);

        // Zero-length request.
        begin_load(8'h30, 9'd0);
        chk("t2_done", done, 1'b1);
        chk("t2_checksum", checksum, 8'h00);
        step();

        // Address wrap.
        begin_load(8'hFE, 9'd3);
        send(8'h01); send(8'h02); send(8'h03);
        chk("t3_checksum", checksum, 8'h06);
        step();
        chk("t3_memFF", dmem[8'hFF], 8'h02);
        chk("t3_mem00", dmem[8'h00], 8'h03);

        // Abort with valid high, then a CPU write gets through.
        begin_load(8'h40, 9'd5);
        send(8'hA1); send(8'hA2);
        in_valid = 1'b1; in_data = 8'hA3; abort = 1'b1;
        step();
        in_valid = 1'b0; abort = 1'b0;
        chk("t4_aborted", aborted, 1'b1);
        chk("t4_words", words_written, 9'd2);
        chk("t4_busy", busy, 1'b0);
        cpu_en_write = 1'b1; cpu_addr = 8'h05; cpu_data = 8'h5A;
        step();
        cpu_en_write = 1'b0;
        chk("t4_cpu_write", dmem[8'h05], 8'h5A);
        chk("t4_no_abort_write", dmem[8'h42], 8'h00);

        // Restart and CPU writes during a load are ignored.
        begin_load(8'h80, 9'd3);
        start = 1'b1; base_addr = 8'hC0; length = 9'd1;
        cpu_en_write = 1'b1; cpu_addr = 8'h90; cpu_data = 8'hEE;
        send(8'h07); send(8'h08); send(8'h09);
        start = 1'b0; cpu_en_write = 1'b0;
        chk("t5_words", words_written, 9'd3);
        step();
        chk("t5_cpu_dropped", dmem[8'h90], 8'h00);
        chk("t5_restart_dropped", dmem[8'hC0], 8'h00);

        // Reset in the middle of a load.
        d0 = done_cnt;
        begin_load(8'h20, 9'd4);
        send(8'h10); send(8'h20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_checksum", checksum, 8'h00);
        chk("t6_words", words_written, 9'd0);
        chk("t6_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_data = 8'h77;
        step(); step();
        in_valid = 1'b0;
        chk("t6_no_write", dmem[8'h22], 8'h00);
        chk("t6_no_done", done_cnt - d0, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 7) == 0);
            base_addr = 8'($urandom);
            length = ($urandom_range(0, 29) == 0) ? 9'($urandom_range(250, 300)) : 9'($urandom_range(0, 11));
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = 8'($urandom);
            abort = ($urandom_range(0, 39) == 0);
            cpu_en_write = ($urandom_range(0, 2) == 0);
            cpu_addr = 8'($urandom);
            cpu_data = 8'($urandom);
            if (rst) begin
                in_valid = 1'b0;
                cpu_en_write = 1'b0;
            end
            step();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; abort = 1'b0; cpu_en_write = 1'b0;
        step();

        mism = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== emem[i]) mism++;
        chk("mem_image", mism, 0);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
